// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Program-download sequencer for the 2^ADDR_W-byte instruction memory.
// Collects a byte stream from the debug/UART receiver, packs it into
// little-endian 32-bit words (first byte received -> bits [7:0]), and writes
// each word with a one-cycle strobe at byte addresses 0, 4, 8, ...
// The CPU is stalled and instruction reads are disabled from load_start
// until the load finishes. The load ends after the HALT_WORD terminator has
// been written, or with load_error set when the last memory slot is written
// without a terminator having been seen.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, the HALT_WORD write is followed by one extra checksum byte
//   that must equal the XOR of every data byte of the load (terminator bytes
//   included). A mismatch sets load_error.
//
// Ports:
//   clk           in   system clock, all state changes on the rising edge
//   reset         in   synchronous active-low reset
//   load_start    in   one-cycle pulse, starts a load (only in IDLE or DONE)
//   rx_valid      in   byte present on rx_data
//   rx_data       in   received byte
//   rx_ready      out  byte accepted this cycle when rx_valid is also high
//   imem_write_en out  one-cycle write strobe to instruction memory
//   imem_data     out  word being written, {b3,b2,b1,b0}
//   imem_addr_wr  out  byte write address, always a multiple of 4
//   imem_read_en  out  instruction-read enable, low while loading
//   cpu_stall     out  holds PC and fetch while loading
//   load_done     out  high once the load has finished
//   word_count    out  words written during the current/last load
//   load_error    out  sticky error flag, cleared by the next load_start
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_write_en,
    output logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] imem_addr_wr,
    output logic              imem_read_en,
    output logic              cpu_stall,
    output logic              load_done,
    output logic [ADDR_W-2:0] word_count,
    output logic              load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
    // Address of the final word slot; writing it without a terminator ends
    // the load so the address never wraps back to 0.
    localparam logic [ADDR_W-1:0] ADDR_LAST = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-2:0] WC_ONE    = (ADDR_W-1)'(1);

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        byte_idx_reg;
    logic [31:0]       word_reg;
    logic [31:0]       word_next;
    logic              accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_reg;
`endif

    assign accept = rx_valid && rx_ready;

    // Word as it looks with the current byte dropped into its lane; on the
    // fourth byte this is the complete word, so it can go straight to
    // imem_data without an extra cycle of latency.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_next[8*gi +: 8] = (byte_idx_reg == 2'(gi)) ? rx_data
                                                                   : word_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            byte_idx_reg  <= '0;
            word_reg      <= '0;
            rx_ready      <= 1'b0;
            imem_write_en <= 1'b0;
            imem_data     <= '0;
            imem_addr_wr  <= '0;
            imem_read_en  <= 1'b1;
            cpu_stall     <= 1'b0;
            load_done     <= 1'b0;
            word_count    <= '0;
            load_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            // The strobe is only ever raised for the single WRITE cycle.
            imem_write_en <= 1'b0;

            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        state_reg    <= S_COLLECT;
                        addr_reg     <= '0;
                        byte_idx_reg <= '0;
                        word_count   <= '0;
                        load_error   <= 1'b0;
                        load_done    <= 1'b0;
                        cpu_stall    <= 1'b1;
                        imem_read_en <= 1'b0;
                        rx_ready     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg     <= '0;
`endif
                    end
                end

                S_COLLECT: begin
                    if (accept) begin
                        word_reg     <= word_next;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg     <= csum_reg ^ rx_data;
`endif
                        if (byte_idx_reg == 2'd3) begin
                            state_reg     <= S_WRITE;
                            rx_ready      <= 1'b0;
                            imem_write_en <= 1'b1;
                            imem_data     <= word_next;
                            imem_addr_wr  <= addr_reg;
                        end
                    end
                end

                S_WRITE: begin
                    addr_reg   <= addr_reg + ADDR_STEP;
                    word_count <= word_count + WC_ONE;
                    if (imem_data == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_reg    <= S_CHECK;
                        rx_ready     <= 1'b1;
`else
                        state_reg    <= S_DONE;
                        load_done    <= 1'b1;
                        cpu_stall    <= 1'b0;
                        imem_read_en <= 1'b1;
`endif
                    end else if (addr_reg == ADDR_LAST) begin
                        // Memory full and no terminator seen.
                        state_reg    <= S_DONE;
                        load_error   <= 1'b1;
                        load_done    <= 1'b1;
                        cpu_stall    <= 1'b0;
                        imem_read_en <= 1'b1;
                    end else begin
                        state_reg <= S_COLLECT;
                        rx_ready  <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        if (rx_data != csum_reg) begin
                            load_error <= 1'b1;
                        end
                        state_reg    <= S_DONE;
                        rx_ready     <= 1'b0;
                        load_done    <= 1'b1;
                        cpu_stall    <= 1'b0;
                        imem_read_en <= 1'b1;
                    end
                end
`endif

                default: begin
                    state_reg <= S_IDLE;
                    rx_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed testbench for imem_loader. Inputs are driven and outputs sampled
// on the falling clock edge. A monitor logs every write strobe and tracks
// strobe-related invariants; each test task checks its own results.
// ---------------------------------------------------------------------------
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_write_en;
    logic [31:0]       imem_data;
    logic [ADDR_W-1:0] imem_addr_wr;
    logic              imem_read_en;
    logic              cpu_stall;
    logic              load_done;
    logic [ADDR_W-2:0] word_count;
    logic              load_error;

    imem_loader #(.ADDR_W(ADDR_W), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .imem_write_en (imem_write_en),
        .imem_data     (imem_data),
        .imem_addr_wr  (imem_addr_wr),
        .imem_read_en  (imem_read_en),
        .cpu_stall     (cpu_stall),
        .load_done     (load_done),
        .word_count    (word_count),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                wr_cyc_q[$];
    int                viol_both   = 0;
    int                viol_consec = 0;
    int                viol_ready  = 0;
    logic              prev_we     = 1'b0;

    logic [7:0] prog [0:7];

    // Write monitor: one line per write transaction.
    always @(negedge clk) begin
        if (imem_write_en === 1'b1) begin
            wr_addr_q.push_back(imem_addr_wr);
            wr_data_q.push_back(imem_data);
            wr_cyc_q.push_back(cyc);
            $display("[TB] write addr=%02h data=%08h", imem_addr_wr, imem_data);
            if (imem_read_en !== 1'b0) viol_both++;
            if (prev_we === 1'b1) viol_consec++;
            if (rx_ready !== 1'b0) viol_ready++;
        end
        prev_we = imem_write_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Offers one byte and returns at the falling edge after it was consumed.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL send_byte: rx_ready never high for byte %02h", b);
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (load_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL wait_done: load_done not seen within 200 cycles");
        end
    endtask

    // Full 8-byte program load, plus the checksum byte when that feature is built.
    task automatic load8(input bit gaps, input logic [7:0] cs);
        clear_log();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(prog[i], gaps && ($urandom_range(0, 1) == 1));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs, 1'b0);
`else
        if (cs == 8'h00) rx_data = 8'h00;
`endif
        rx_valid = 1'b0;
        wait_done();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        tests++; if (rx_ready !== 1'b0)      begin fails++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
        tests++; if (imem_write_en !== 1'b0) begin fails++; $display("FAIL reset_write_en: got %b expected 0", imem_write_en); end
        tests++; if (imem_data !== 32'h0)    begin fails++; $display("FAIL reset_data: got %h expected 0", imem_data); end
        tests++; if (imem_addr_wr !== 8'h0)  begin fails++; $display("FAIL reset_addr: got %h expected 0", imem_addr_wr); end
        tests++; if (imem_read_en !== 1'b1)  begin fails++; $display("FAIL reset_read_en: got %b expected 1", imem_read_en); end
        tests++; if (cpu_stall !== 1'b0)     begin fails++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
        tests++; if (load_done !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b expected 0", load_done); end
        tests++; if (word_count !== 7'd0)    begin fails++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
        tests++; if (load_error !== 1'b0)    begin fails++; $display("FAIL reset_error: got %b expected 0", load_error); end
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal();
        clear_log();
        pulse_start();
        tests++; if (cpu_stall !== 1'b1)    begin fails++; $display("FAIL start_stall: got %b expected 1", cpu_stall); end
        tests++; if (imem_read_en !== 1'b0) begin fails++; $display("FAIL start_read_en: got %b expected 0", imem_read_en); end
        tests++; if (rx_ready !== 1'b1)     begin fails++; $display("FAIL start_rx_ready: got %b expected 1", rx_ready); end
        for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h33, 1'b0);
`endif
        rx_valid = 1'b0;
        wait_done();
        tests++;
        if (wr_data_q.size() != 2) begin
            fails++; $display("FAIL normal_count: got %0d writes expected 2", wr_data_q.size());
        end else begin
            tests++; if (wr_data_q[0] !== 32'h2000_0013) begin fails++; $display("FAIL normal_data0: got %h expected 20000013", wr_data_q[0]); end
            tests++; if (wr_addr_q[0] !== 8'h00)         begin fails++; $display("FAIL normal_addr0: got %h expected 00", wr_addr_q[0]); end
            tests++; if (wr_data_q[1] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL normal_data1: got %h expected ffffffff", wr_data_q[1]); end
            tests++; if (wr_addr_q[1] !== 8'h04)         begin fails++; $display("FAIL normal_addr1: got %h expected 04", wr_addr_q[1]); end
            tests++; if (wr_cyc_q[1] - wr_cyc_q[0] != 5) begin fails++; $display("FAIL normal_latency: got %0d cycles between strobes expected 5", wr_cyc_q[1] - wr_cyc_q[0]); end
        end
        tests++; if (load_done !== 1'b1)    begin fails++; $display("FAIL normal_done: got %b expected 1", load_done); end
        tests++; if (word_count !== 7'd2)   begin fails++; $display("FAIL normal_word_count: got %0d expected 2", word_count); end
        tests++; if (cpu_stall !== 1'b0)    begin fails++; $display("FAIL normal_stall: got %b expected 0", cpu_stall); end
        tests++; if (load_error !== 1'b0)   begin fails++; $display("FAIL normal_error: got %b expected 0", load_error); end
        tests++; if (imem_read_en !== 1'b1) begin fails++; $display("FAIL normal_read_en: got %b expected 1", imem_read_en); end
        tests++; if (rx_ready !== 1'b0)     begin fails++; $display("FAIL normal_rx_ready: got %b expected 0", rx_ready); end
    endtask

    task automatic test_gaps();
        load8(1'b1, 8'h33);
        tests++;
        if (wr_data_q.size() != 2) begin
            fails++; $display("FAIL gaps_count: got %0d writes expected 2", wr_data_q.size());
        end else begin
            tests++; if (wr_data_q[0] !== 32'h2000_0013) begin fails++; $display("FAIL gaps_data0: got %h expected 20000013", wr_data_q[0]); end
            tests++; if (wr_data_q[1] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL gaps_data1: got %h expected ffffffff", wr_data_q[1]); end
            tests++; if (wr_addr_q[1] !== 8'h04)         begin fails++; $display("FAIL gaps_addr1: got %h expected 04", wr_addr_q[1]); end
        end
        tests++; if (word_count !== 7'd2) begin fails++; $display("FAIL gaps_word_count: got %0d expected 2", word_count); end
        tests++; if (viol_ready != 0)     begin fails++; $display("FAIL gaps_rx_ready_in_write: got %0d expected 0", viol_ready); end
    endtask

    // load_start while collecting must not reset the partially built word.
    task automatic test_ignore_start();
        clear_log();
        pulse_start();
        send_byte(prog[0], 1'b0);
        send_byte(prog[1], 1'b0);
        rx_valid = 1'b0;
        pulse_start();
        for (int i = 2; i < 8; i++) send_byte(prog[i], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h33, 1'b0);
`endif
        rx_valid = 1'b0;
        wait_done();
        tests++;
        if (wr_data_q.size() != 2) begin
            fails++; $display("FAIL ignore_count: got %0d writes expected 2", wr_data_q.size());
        end else begin
            tests++; if (wr_data_q[0] !== 32'h2000_0013) begin fails++; $display("FAIL ignore_data0: got %h expected 20000013", wr_data_q[0]); end
        end
        tests++; if (word_count !== 7'd2) begin fails++; $display("FAIL ignore_word_count: got %0d expected 2", word_count); end
    endtask

    task automatic test_overflow();
        int bad;
        clear_log();
        pulse_start();
        for (int i = 0; i < 256; i++) send_byte(8'h00, 1'b0);
        rx_valid = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        tests++; if (wr_data_q.size() != 64) begin fails++; $display("FAIL overflow_count: got %0d writes expected 64", wr_data_q.size()); end
        bad = 0;
        for (int i = 0; i < wr_data_q.size(); i++) begin
            if (wr_addr_q[i] !== 8'(i * 4) || wr_data_q[i] !== 32'h0) bad++;
        end
        tests++; if (bad != 0)              begin fails++; $display("FAIL overflow_writes: got %0d bad writes expected 0", bad); end
        tests++; if (load_error !== 1'b1)   begin fails++; $display("FAIL overflow_error: got %b expected 1", load_error); end
        tests++; if (word_count !== 7'd64)  begin fails++; $display("FAIL overflow_word_count: got %0d expected 64", word_count); end
        tests++; if (load_done !== 1'b1)    begin fails++; $display("FAIL overflow_done: got %b expected 1", load_done); end
        tests++; if (imem_read_en !== 1'b1) begin fails++; $display("FAIL overflow_read_en: got %b expected 1", imem_read_en); end
        // A new load from DONE clears the sticky error.
        load8(1'b0, 8'h33);
        tests++; if (load_error !== 1'b0)   begin fails++; $display("FAIL overflow_error_clear: got %b expected 0", load_error); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rx_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (wr_data_q.size() != 0) begin fails++; $display("FAIL midreset_writes: got %0d writes expected 0", wr_data_q.size()); end
        tests++; if (cpu_stall !== 1'b0)    begin fails++; $display("FAIL midreset_stall: got %b expected 0", cpu_stall); end
        tests++; if (imem_read_en !== 1'b1) begin fails++; $display("FAIL midreset_read_en: got %b expected 1", imem_read_en); end
        tests++; if (rx_ready !== 1'b0)     begin fails++; $display("FAIL midreset_rx_ready: got %b expected 0", rx_ready); end
        load8(1'b0, 8'h33);
        tests++;
        if (wr_data_q.size() != 2) begin
            fails++; $display("FAIL midreset_count: got %0d writes expected 2", wr_data_q.size());
        end else begin
            tests++; if (wr_data_q[0] !== 32'h2000_0013) begin fails++; $display("FAIL midreset_data0: got %h expected 20000013", wr_data_q[0]); end
            tests++; if (wr_addr_q[0] !== 8'h00)         begin fails++; $display("FAIL midreset_addr0: got %h expected 00", wr_addr_q[0]); end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        load8(1'b0, 8'h33);
        tests++; if (load_error !== 1'b0) begin fails++; $display("FAIL checksum_good: got error %b expected 0", load_error); end
        load8(1'b0, 8'h34);
        tests++; if (load_error !== 1'b1) begin fails++; $display("FAIL checksum_bad: got error %b expected 1", load_error); end
        tests++; if (load_done !== 1'b1)  begin fails++; $display("FAIL checksum_done: got %b expected 1", load_done); end
    endtask
`endif

    task automatic test_invariants();
        tests++; if (viol_both != 0)   begin fails++; $display("FAIL inv_read_and_write: got %0d expected 0", viol_both); end
        tests++; if (viol_consec != 0) begin fails++; $display("FAIL inv_consecutive_strobe: got %0d expected 0", viol_consec); end
        tests++; if (viol_ready != 0)  begin fails++; $display("FAIL inv_ready_in_write: got %0d expected 0", viol_ready); end
    endtask

    initial begin
        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h20;
        prog[4] = 8'hFF; prog[5] = 8'hFF; prog[6] = 8'hFF; prog[7] = 8'hFF;
        @(negedge clk);
        test_reset();
        test_normal();
        test_gaps();
        test_ignore_start();
        test_overflow();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequences the 256-byte instruction memory (64 x 32-bit words, little-endian byte lanes) during program download.
- Takes a byte stream from the debug/UART receiver and assembles little-endian 32-bit words.
- Issues one-cycle write strobes at word-aligned addresses 0, 4, 8, … and holds the pipeline in stall until the program is loaded.
- After loading, it enables instruction reads and releases the CPU.

Parameters:
- ADDR_W, 8, instruction-memory byte-address width; memory depth is 2^ADDR_W bytes.
- HALT_WORD, 32'hFFFF_FFFF, terminator word; it is written to memory and then ends the load.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- load_start  in  1  one-cycle pulse; begins a new load. Honoured only in IDLE or DONE.
- rx_valid  in  1  byte available on rx_data this cycle.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader accepts a byte this cycle; a byte is consumed when rx_valid && rx_ready.
- imem_write_en  out  1  write strobe to instruction memory.
- imem_data  out  32  word to write, {b3,b2,b1,b0}, with b0 the first byte received.
- imem_addr_wr  out  ADDR_W  byte write address (always a multiple of 4).
- imem_read_en  out  1  instruction-read enable; low while loading.
- cpu_stall  out  1  holds PC and fetch; high from load_start until DONE.
- load_done  out  1  level; high in DONE.
- word_count  out  ADDR_W-1  number of words written in the current/last load.
- load_error  out  1  sticky until next load_start.

Behaviour:
- Reset values: state IDLE, rx_ready=0, imem_write_en=0, imem_data=0, imem_addr_wr=0, imem_read_en=1, cpu_stall=0, load_done=0, word_count=0, load_error=0, byte index=0.
- IDLE: waits for load_start. On load_start:
  - enter COLLECT;
  - clear addr, word_count, byte index, load_error;
  - set cpu_stall=1 and imem_read_en=0 on the next cycle.
- COLLECT:
  - rx_ready=1.
  - Each accepted byte goes into lane[byte index]; byte index increments mod 4.
  - The 4th accepted byte moves to WRITE on the next cycle; rx_ready=0 in that cycle.
- WRITE (exactly 1 cycle):
  - imem_write_en=1, imem_data=assembled word, imem_addr_wr=current addr.
  - Next cycle: addr += 4, word_count += 1.
  - If word == HALT_WORD, go to DONE.
  - Else if addr was 2^ADDR_W-4 (last slot), go to DONE with load_error=1 (no terminator seen, memory full).
  - Otherwise return to COLLECT.
  - Latency: the last byte accepted at cycle N gives write strobe at N+1; the next byte can be accepted at N+2.
- DONE: load_done=1, cpu_stall=0, imem_read_en=1, rx_ready=0. A new load_start restarts the load (same as from IDLE).
- Address wrap: addr never exceeds 2^ADDR_W-4. The full condition terminates the load, so writes never wrap.
- rx_valid outside COLLECT: ignored (not consumed).
- load_start during COLLECT/WRITE: ignored.
- Reset mid-load (reset=0 in any state): synchronous return to reset values on that edge.
  - Any partially assembled word is discarded with no write strobe.
  - Memory contents are not touched by this block.
- imem_write_en is never high for more than one consecutive cycle; imem_read_en and imem_write_en are never both 1.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - after the HALT_WORD write, state CHECK accepts one extra byte;
  - a running XOR of all data bytes received (including the HALT_WORD bytes) is compared to it;
  - a mismatch sets load_error=1;
  - then DONE.
- When undefined: no CHECK state; HALT_WORD write goes directly to DONE; the checksum register is not synthesized.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random rx_valid → all outputs at reset values; imem_read_en=1, rx_ready=0.
- Normal load: load_start, then bytes 13 00 00 20 FF FF FF FF → two write strobes:
  - 0x20000013 @ addr 0x00;
  - 0xFFFFFFFF @ 0x04;
  - then load_done=1, word_count=2, cpu_stall=0, load_error=0.
- Backpressure/gaps: same bytes with rx_valid low on random cycles → identical writes; rx_ready=0 in each WRITE cycle; no byte lost or duplicated.
- Overflow: 256 bytes of 0x00 with no terminator → 64 strobes at 0x00..0xFC, then DONE with load_error=1; no strobe to 0x00 after 0xFC.
- Reset mid-word: after 2 bytes, reset=0 for one cycle → no write strobe; a following load_start + 8 bytes writes from addr 0x00.
- Checksum (macro defined): bytes 13 00 00 20 FF FF FF FF then 0x33 → load_error=0; with 0x34 instead → load_error=1.
